// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD game timer: FSM state encoding,
// BCD digit limits and the prescaler width helper.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused,
    StExpired
  } timer_state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;
  localparam logic [3:0] BCD_ZERO = 4'h0;

  // Width of a down-counter that must hold TICK_DIV-1.
  function automatic int unsigned tick_div_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_digit_stage.sv
// One BCD digit of the timer count: register plus +/-1 step with carry/borrow
// ripple. Steps only when the whole chain is enabled and this digit's carry-in is set.
module bcd_digit_stage
  import timer_pkg::*;
#(
  parameter logic [3:0] InitVal = 4'h0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic [3:0] digit_next_o,
  output logic       cout_o,
  output logic       is_zero_o,
  output logic       is_nine_o
);

  logic [3:0] digit_q;

  assign digit_o   = digit_q;
  assign is_zero_o = (digit_q == BCD_ZERO);
  assign is_nine_o = (digit_q == BCD_NINE);
  assign cout_o    = cin_i & (up_i ? is_nine_o : is_zero_o);

  always_comb begin
    digit_next_o = digit_q;
    if (cin_i) begin
      if (up_i) begin
        digit_next_o = is_nine_o ? BCD_ZERO : digit_q + 4'd1;
      end else begin
        digit_next_o = is_zero_o ? BCD_NINE : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= InitVal;
    end else if (load_i) begin
      digit_q <= load_val_i;
    end else if (step_i) begin
      digit_q <= digit_next_o;
    end
  end

endmodule

// File: rtl/game_timer_bcd.sv
// BCD game timer: loadable up/down counter with prescaler, pause and expiry.
// Define TIMER_WARN_EN to add the blinking low-time Warn output.
module game_timer_bcd
  import timer_pkg::*;
#(
  parameter int unsigned         DIGITS   = 2,
  parameter int unsigned         CLK_FREQ = 50000000,
  parameter int unsigned         TICK_HZ  = 1,
  parameter logic [4*DIGITS-1:0] INIT_BCD = 8'h60,
  parameter logic [4*DIGITS-1:0] WARN_BCD = 8'h10
) (
  input  logic                ClockIn,
  input  logic                Reset,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadValue,
  input  logic                Mode,
  input  logic                Start,
  input  logic                Pause,
  output logic [4*DIGITS-1:0] BcdOut,
  output logic                Running,
  output logic                Expired,
  output logic                ExpiredPulse,
`ifdef TIMER_WARN_EN
  output logic                Warn,
`endif
  output logic                Tick
);

  localparam int unsigned W       = 4 * DIGITS;
  localparam int unsigned TickDiv = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW      = tick_div_width(TickDiv);
  localparam logic [PW-1:0] PresMax = PW'(TickDiv - 1);

  timer_state_e  state_q;
  logic [PW-1:0] presc_q;
  logic [W-1:0]  limit_q;
  logic          mode_q;
  logic          running_q, expired_q, xpulse_q, tick_q;

  logic              cnt_load, cnt_step;
  logic [W-1:0]      cnt_load_val, load_clamped, cnt_q, cnt_next;
  logic [DIGITS-1:0] zero_vec, nine_vec;
  logic [DIGITS:0]   carry;
  logic              term_now, term_next;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign load_clamped[4*g +: 4] =
        (LoadValue[4*g +: 4] > BCD_NINE) ? BCD_NINE : LoadValue[4*g +: 4];

    bcd_digit_stage #(
      .InitVal(INIT_BCD[4*g +: 4])
    ) u_stage (
      .clk_i       (ClockIn),
      .rst_i       (Reset),
      .load_i      (cnt_load),
      .load_val_i  (cnt_load_val[4*g +: 4]),
      .step_i      (cnt_step),
      .up_i        (mode_q),
      .cin_i       (carry[g]),
      .digit_o     (cnt_q[4*g +: 4]),
      .digit_next_o(cnt_next[4*g +: 4]),
      .cout_o      (carry[g+1]),
      .is_zero_o   (zero_vec[g]),
      .is_nine_o   (nine_vec[g])
    );
  end

  // Up mode also stops on an all-nines count so the counter can never wrap.
  assign term_now  = mode_q ? ((cnt_q == limit_q) || (&nine_vec)) : (&zero_vec);
  assign term_next = mode_q ? ((cnt_next == limit_q) || carry[DIGITS]) : (cnt_next == '0);

  always_comb begin
    cnt_load     = 1'b0;
    cnt_step     = 1'b0;
    cnt_load_val = Mode ? '0 : load_clamped;
    unique case (state_q)
      StIdle, StExpired: cnt_load = Load;
      StRun:             cnt_step = !term_now && !Pause && (presc_q == '0);
      default:           ;
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q   <= StIdle;
      presc_q   <= PresMax;
      limit_q   <= INIT_BCD;
      mode_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      xpulse_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q   <= cnt_step;
      xpulse_q <= 1'b0;
      unique case (state_q)
        StIdle, StExpired: begin
          if (Load) begin
            limit_q   <= load_clamped;
            state_q   <= StIdle;
            expired_q <= 1'b0;
          end else if (state_q == StIdle && Start) begin
            state_q   <= StRun;
            running_q <= 1'b1;
            mode_q    <= Mode;
            presc_q   <= PresMax;
          end
        end
        StRun: begin
          if (term_now || (cnt_step && term_next)) begin
            state_q   <= StExpired;
            running_q <= 1'b0;
            expired_q <= 1'b1;
            xpulse_q  <= 1'b1;
          end else if (Pause) begin
            state_q   <= StPaused;
            running_q <= 1'b0;
          end
          if (cnt_step) begin
            presc_q <= PresMax;
          end else if (!term_now && !Pause) begin
            presc_q <= presc_q - 1'b1;
          end
        end
        StPaused: begin
          if (!Pause) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BcdOut       = cnt_q;
  assign Running      = running_q;
  assign Expired      = expired_q;
  assign ExpiredPulse = xpulse_q;
  assign Tick         = tick_q;

`ifdef TIMER_WARN_EN
  logic         warn_q, active_next, mode_next;
  logic [W-1:0] cnt_after;

  always_comb begin
    cnt_after   = cnt_step ? cnt_next : cnt_q;
    mode_next   = (state_q == StRun || state_q == StPaused) ? mode_q : Mode;
    active_next = 1'b0;
    unique case (state_q)
      StIdle:   active_next = Start && !Load;
      StRun:    active_next = !term_now && !(cnt_step && term_next);
      StPaused: active_next = 1'b1;
      default:  active_next = 1'b0;
    endcase
  end

  // Below 6 the flag blinks: it toggles on every step instead of staying high.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      warn_q <= 1'b0;
    end else if (active_next && !mode_next && (cnt_after <= WARN_BCD)) begin
      if (cnt_after <= W'(5)) begin
        warn_q <= cnt_step ? ~warn_q : warn_q;
      end else begin
        warn_q <= 1'b1;
      end
    end else begin
      warn_q <= 1'b0;
    end
  end

  assign Warn = warn_q;
`endif

endmodule
